// File: rtl/psum_accum.sv
// Partial-sum accumulator behind the 1-D conv PE: sums NUM_PASS PE runs, then drains the row.
// Optional RELU_EN build macro clamps negative drained words to zero at the output mux.
module psum_accum #(
  parameter int D_WIDTH  = 32,
  parameter int NUM_OUT  = 3,
  parameter int NUM_PASS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pe_done,
  input  logic [D_WIDTH-1:0] pe_out0,
  input  logic [D_WIDTH-1:0] pe_out1,
  input  logic [D_WIDTH-1:0] pe_out2,
  output logic               accept_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [1:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               row_done,
  output logic [3:0]         pass_cnt,
  output logic               drop_err
);

  typedef enum logic {S_COLLECT, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_pass_cnt;
  logic [1:0]         r_out_idx;
  logic               r_row_done;
  logic               r_drop_err;
  logic [D_WIDTH-1:0] w_pe_out [0:2];
  logic [D_WIDTH-1:0] w_acc    [0:2];
  logic [D_WIDTH-1:0] w_sel;
  logic               w_accept;
  logic               w_first_pass;
  logic               w_last_pass;
  logic               w_beat;
  logic               w_last_beat;

  assign w_pe_out[0] = pe_out0;
  assign w_pe_out[1] = pe_out1;
  assign w_pe_out[2] = pe_out2;

  assign w_accept     = pe_done && (r_state == S_COLLECT);
  assign w_first_pass = (r_pass_cnt == 4'd0);
  assign w_last_pass  = (r_pass_cnt == 4'(NUM_PASS - 1));
  assign w_beat       = (r_state == S_DRAIN) && out_ready;
  assign w_last_beat  = w_beat && (r_out_idx == 2'(NUM_OUT - 1));

  // The first pass overwrites, so a finished row never needs an explicit clear.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_acc
      if (gi < NUM_OUT) begin : g_used
        logic [D_WIDTH-1:0] r_acc;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_acc <= '0;
          end else if (w_accept) begin
            r_acc <= w_first_pass ? w_pe_out[gi] : r_acc + w_pe_out[gi];
          end
        end
        assign w_acc[gi] = r_acc;
      end else begin : g_unused
        assign w_acc[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    accept_ready = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_COLLECT: begin
        accept_ready = 1'b1;
        if (w_accept && w_last_pass) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (w_last_beat) w_state_next = S_COLLECT;
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_cnt <= 4'd0;
      r_out_idx  <= 2'd0;
      r_row_done <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_row_done <= w_last_beat;
      if (pe_done && (r_state == S_DRAIN)) r_drop_err <= 1'b1;
      if (w_accept) r_pass_cnt <= w_last_pass ? 4'd0 : r_pass_cnt + 4'd1;
      if (w_beat) r_out_idx <= w_last_beat ? 2'd0 : r_out_idx + 2'd1;
    end
  end

  always_comb begin
    w_sel = '0;
    case (r_out_idx)
      2'd0:    w_sel = w_acc[0];
      2'd1:    w_sel = w_acc[1];
      2'd2:    w_sel = w_acc[2];
      default: w_sel = '0;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef RELU_EN
      out_data = w_sel[D_WIDTH-1] ? '0 : w_sel;
`else
      out_data = w_sel;
`endif
    end
  end

  assign out_idx  = r_out_idx;
  assign row_done = r_row_done;
  assign pass_cnt = r_pass_cnt;
  assign drop_err = r_drop_err;

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Downstream neighbour of the 1-D convolution PE. Captures the PE's three partial sums on each PE done pulse and accumulates them over NUM_PASS consecutive PE runs, for example one run per kernel row or input channel.
- After the last pass, drains the finished output row one word per beat over a valid/ready stream to the global buffer or write-back stage.

Parameters:
- D_WIDTH, 32, width of every psum, accumulator and output word.
- NUM_OUT, 3, psums per PE run (iact_size - kernel_size + 1); fixed port count pe_out0..pe_out2, so legal range is 1..3. Unused inputs are ignored.
- NUM_PASS, 3, PE runs accumulated per output row; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- pe_done  input  1  single-cycle pulse from the PE; pe_out* are valid in that cycle.
- pe_out0  input  D_WIDTH  psum 0.
- pe_out1  input  D_WIDTH  psum 1.
- pe_out2  input  D_WIDTH  psum 2.
- accept_ready  output  1  high when a pe_done will be accepted; the controller must not start the PE while this is low.
- out_data  output  D_WIDTH  drained accumulator word.
- out_idx  output  2  index (0..NUM_OUT-1) of out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- row_done  output  1  one-cycle pulse after the last beat of a row is accepted.
- pass_cnt  output  4  passes accumulated so far in the current row.
- drop_err  output  1  sticky; a pe_done arrived while accept_ready was low.

Behaviour:
- Reset (rst=1 at posedge, takes priority over everything including mid-drain):
  - state=COLLECT; acc[0..2]=0; pass_cnt=0; out_idx=0.
  - out_valid=0, row_done=0, drop_err=0, accept_ready=1, out_data=0.
- State COLLECT:
  - accept_ready=1, out_valid=0.
  - On posedge with pe_done=1 and pass_cnt==0: acc[i] <= pe_out_i, overwriting stale data with no prior clear needed.
  - On posedge with pe_done=1 and pass_cnt>0: acc[i] <= acc[i] + pe_out_i.
  - Only i < NUM_OUT are updated.
  - If pass_cnt == NUM_PASS-1 on that edge: pass_cnt <= 0 and state <= DRAIN with out_idx=0. Otherwise pass_cnt <= pass_cnt+1.
  - NUM_PASS=1 means each pe_done goes straight to DRAIN.
- State DRAIN:
  - accept_ready=0; out_valid=1; out_data=acc[out_idx], driven combinationally from registers.
  - On valid&&ready: if out_idx < NUM_OUT-1 then out_idx++. Otherwise out_idx <= 0, state <= COLLECT, row_done <= 1 for one cycle.
  - out_data/out_idx must hold stable while out_valid && !out_ready (AXI-style; valid never drops without a handshake).
  - First beat is presented the cycle after the final pe_done. NUM_OUT beats take a minimum of NUM_OUT cycles with out_ready held high.
  - The first pe_done of the next row is accepted in the cycle row_done is high.
- Arithmetic: two's-complement add, wraps modulo 2^D_WIDTH, no saturation, no overflow flag.
- pe_done while in DRAIN:
  - Data is discarded, acc and pass_cnt are unchanged, drop_err <= 1.
  - drop_err clears only on rst.
- pe_done held high for multiple cycles counts once per cycle. The upstream controller guarantees single-cycle pulses.
- out_data is 0 whenever out_valid=0.

Optional Feature:
- RELU_EN defined:
  - out_data = acc[out_idx] when its MSB is 0, else 0. Accumulators are interpreted as signed.
  - The clamp is applied only at the output mux; the stored acc is unmodified.
- RELU_EN undefined: out_data = acc[out_idx] raw.

Test Plan:
1. rst, NUM_PASS=3, pe_done×3 with (1,2,3), (10,20,30), (100,200,300), out_ready=1 -> beats (idx0,111), (idx1,222), (idx2,333) on consecutive cycles starting the cycle after the 3rd pe_done; row_done pulses once; pass_cnt returns to 0.
2. Back-pressure: during DRAIN hold out_ready=0 for 4 cycles, then pulse it -> out_valid stays 1, out_data/out_idx stable, one beat per ready pulse; no beat is lost or duplicated.
3. pe_done with (5,5,5) during DRAIN -> drop_err=1 and stays 1; drained values are unaffected; next row's sum excludes the 5s; drop_err clears only after rst.
4. Wrap: acc0 path with 0xFFFFFFFF + 0x00000002 + 0 -> out_data=0x00000001. With RELU_EN, -7 + 3 + 1 (0xFFFFFFFD) -> out_data=0; without it -> 0xFFFFFFFD.
5. Reset mid-operation: rst after 2 passes, and again during DRAIN at out_idx=1 -> out_valid=0, pass_cnt=0, accept_ready=1 next cycle. A fresh 3-pass row of (1,1,1) drains as 3,3,3 with no stale sum.
6. Back-to-back rows: new pe_done in the row_done cycle with (7,8,9) is accepted; second row (with NUM_PASS=1 build) drains 7,8,9 immediately.
